// File: rtl/sub_float64_sigs.sv
`default_nettype none
// ============================================================================
// Module   : sub_float64_sigs
// Purpose  : float64 magnitude subtraction with round-to-nearest-even
//            (SoftFloat subFloat64Sigs), driven by an ap_start/ap_done
//            handshake. Optional macro SUB_KEYLOCK_EN enables the output keylock.
// Revision : 1.0 - initial release
// ============================================================================
module sub_float64_sigs #(
    parameter logic [21:0] LOCK_KEY = 22'h0
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        zSign,
    output logic [63:0] ap_return,
    input  logic [21:0] working_key
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_SUB   = 2'd2,
        S_ROUND = 2'd3
    } state_t;

    localparam logic [63:0] C_HIDDEN  = 64'h4000_0000_0000_0000;
    localparam logic [63:0] C_QUIET   = 64'h0008_0000_0000_0000;
    localparam logic [63:0] C_DEF_NAN = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [10:0] C_EXP_MAX = 11'h7FF;

    // Right shift that ORs every bit shifted out into the result LSB.
    function automatic logic [63:0] jam_shift(input logic [63:0] v, input logic [12:0] cnt);
        logic [63:0] res;
        if (cnt == 13'd0) begin
            res = v;
        end else if (cnt < 13'd64) begin
            res = (v >> cnt) | {63'd0, |(v << (13'd64 - cnt))};
        end else begin
            res = {63'd0, |v};
        end
        return res;
    endfunction

    function automatic logic [6:0] clz64(input logic [63:0] v);
        logic [6:0] n;
        n = 7'd64;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) n = 7'(63 - i);
        end
        return n;
    endfunction

    state_t      r_state_q, w_state_d;
    logic [63:0] r_a_q, w_a_d, r_b_q, w_b_d;
    logic        r_zsign_q, w_zsign_d;
    logic        r_spec_q, w_spec_d;
    logic [63:0] r_spec_val_q, w_spec_val_d;
    logic [63:0] r_big_q, w_big_d, r_small_q, w_small_d;
    logic [10:0] r_zexp_q, w_zexp_d;
    logic        r_sign_q, w_sign_d;
    logic [63:0] r_ret_q, w_ret_d;

    logic [10:0] w_a_exp, w_b_exp;
    logic [63:0] w_a_sig, w_b_sig, w_nan_val;
    logic        w_b_nan;
    logic [12:0] w_diff, w_neg;

    logic [63:0] w_zsig, w_norm, w_den, w_rsig, w_res;
    logic [6:0]  w_shift;
    logic [12:0] w_zexp_n;
    logic [10:0] w_fexp;
    logic        w_ovf;

    always_comb begin
        w_state_d = r_state_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_zsign_d = r_zsign_q;
        case (r_state_q)
            S_IDLE: begin
                if (ap_start) begin
                    w_state_d = S_ALIGN;
                    w_a_d     = a;
                    w_b_d     = b;
                    w_zsign_d = zSign;
                end
            end
            S_ALIGN: w_state_d = S_SUB;
            S_SUB:   w_state_d = S_ROUND;
            default: w_state_d = S_IDLE;
        endcase
    end

    assign w_a_exp   = r_a_q[62:52];
    assign w_b_exp   = r_b_q[62:52];
    assign w_a_sig   = {2'b00, r_a_q[51:0], 10'd0};
    assign w_b_sig   = {2'b00, r_b_q[51:0], 10'd0};
    assign w_b_nan   = (w_b_exp == C_EXP_MAX) && (r_b_q[51:0] != 52'd0);
    assign w_nan_val = w_b_nan ? (r_b_q | C_QUIET) : (r_a_q | C_QUIET);
    assign w_diff    = {2'b00, w_a_exp} - {2'b00, w_b_exp};
    assign w_neg     = 13'd0 - w_diff;

    // Alignment: pick the larger operand, jam-shift the smaller, resolve specials.
    always_comb begin
        w_spec_d     = 1'b0;
        w_spec_val_d = 64'd0;
        w_big_d      = w_a_sig;
        w_small_d    = w_b_sig;
        w_zexp_d     = w_a_exp;
        w_sign_d     = r_zsign_q;
        if (!w_diff[12] && (w_diff != 13'd0)) begin
            if (w_a_exp == C_EXP_MAX) begin
                w_spec_d     = 1'b1;
                w_spec_val_d = (w_a_sig != 64'd0) ? w_nan_val : r_a_q;
            end
            w_big_d   = w_a_sig | C_HIDDEN;
            w_small_d = (w_b_exp == 11'd0) ? jam_shift(w_b_sig, w_diff - 13'd1)
                                           : jam_shift(w_b_sig | C_HIDDEN, w_diff);
        end else if (w_diff[12]) begin
            if (w_b_exp == C_EXP_MAX) begin
                w_spec_d     = 1'b1;
                w_spec_val_d = (w_b_sig != 64'd0) ? w_nan_val : {~r_zsign_q, C_EXP_MAX, 52'd0};
            end
            w_big_d   = w_b_sig | C_HIDDEN;
            w_small_d = (w_a_exp == 11'd0) ? jam_shift(w_a_sig, w_neg - 13'd1)
                                           : jam_shift(w_a_sig | C_HIDDEN, w_neg);
            w_zexp_d  = w_b_exp;
            w_sign_d  = ~r_zsign_q;
        end else begin
            if (w_a_exp == C_EXP_MAX) begin
                w_spec_d     = 1'b1;
                w_spec_val_d = ((w_a_sig | w_b_sig) != 64'd0) ? w_nan_val : C_DEF_NAN;
            end else if (w_a_sig == w_b_sig) begin
                w_spec_d     = 1'b1;
                w_spec_val_d = 64'd0;
            end
            // Equal exponents: hidden bits cancel, so plain field subtraction suffices.
            w_zexp_d = (w_a_exp == 11'd0) ? 11'd1 : w_a_exp;
            if (w_b_sig > w_a_sig) begin
                w_big_d   = w_b_sig;
                w_small_d = w_a_sig;
                w_sign_d  = ~r_zsign_q;
            end
        end
    end

    // Subtract, normalize, round and pack; captured into ap_return on leaving SUB.
    always_comb begin
        w_zsig   = r_big_q - r_small_q;
        w_shift  = clz64(w_zsig) - 7'd1;
        w_norm   = w_zsig << w_shift;
        w_zexp_n = {2'b00, r_zexp_q} - 13'd1 - {6'd0, w_shift};
        w_ovf    = (!w_zexp_n[12] && (w_zexp_n > 13'h7FD)) ||
                   ((w_zexp_n == 13'h7FD) && (w_norm >= 64'h7FFF_FFFF_FFFF_FE00));
        if (w_zexp_n[12]) begin
            w_den  = jam_shift(w_norm, 13'd0 - w_zexp_n);
            w_fexp = 11'd0;
        end else begin
            w_den  = w_norm;
            w_fexp = w_zexp_n[10:0];
        end
        w_rsig = (w_den + 64'h200) >> 10;
        if (w_den[9:0] == 10'h200) w_rsig[0] = 1'b0;
        if (w_rsig == 64'd0) w_fexp = 11'd0;
        w_res = {r_sign_q, 63'd0} + {1'b0, w_fexp, 52'd0} + w_rsig;
        if (w_ovf)    w_res = {r_sign_q, C_EXP_MAX, 52'd0};
        if (r_spec_q) w_res = r_spec_val_q;
        w_ret_d = w_res;
`ifdef SUB_KEYLOCK_EN
        w_ret_d[21:0] = w_res[21:0] ^ (working_key ^ LOCK_KEY);
`endif
        if (r_state_q != S_SUB) w_ret_d = r_ret_q;
    end

`ifndef SUB_KEYLOCK_EN
    logic w_unused_key;
    assign w_unused_key = ^{working_key, LOCK_KEY};
`endif

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state_q    <= S_IDLE;
            r_a_q        <= 64'd0;
            r_b_q        <= 64'd0;
            r_zsign_q    <= 1'b0;
            r_spec_q     <= 1'b0;
            r_spec_val_q <= 64'd0;
            r_big_q      <= 64'd0;
            r_small_q    <= 64'd0;
            r_zexp_q     <= 11'd0;
            r_sign_q     <= 1'b0;
            r_ret_q      <= 64'd0;
        end else begin
            r_state_q    <= w_state_d;
            r_a_q        <= w_a_d;
            r_b_q        <= w_b_d;
            r_zsign_q    <= w_zsign_d;
            r_spec_q     <= w_spec_d;
            r_spec_val_q <= w_spec_val_d;
            r_big_q      <= w_big_d;
            r_small_q    <= w_small_d;
            r_zexp_q     <= w_zexp_d;
            r_sign_q     <= w_sign_d;
            r_ret_q      <= w_ret_d;
        end
    end

    assign ap_done   = (r_state_q == S_ROUND);
    assign ap_ready  = (r_state_q == S_ROUND);
    assign ap_idle   = (r_state_q == S_IDLE) && !ap_start;
    assign ap_return = r_ret_q;

endmodule
`default_nettype wire

// File: tb/tb_sub_float64_sigs.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_float64_sigs
// Purpose  : self-checking bench for sub_float64_sigs; reference results come
//            from IEEE real arithmetic plus explicit NaN/infinity rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sub_float64_sigs;

    localparam logic [63:0] C_QUIET = 64'h0008_0000_0000_0000;
    localparam logic [21:0] C_LOCK  = 22'h0;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        ap_start = 1'b0;
    logic        ap_done, ap_idle, ap_ready;
    logic [63:0] a = 64'd0;
    logic [63:0] b = 64'd0;
    logic        zSign = 1'b0;
    logic [63:0] ap_return;
    logic [21:0] working_key = 22'd0;

    int checks = 0;
    int failures = 0;

    always #5 ap_clk = ~ap_clk;

    sub_float64_sigs #(.LOCK_KEY(C_LOCK)) dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .ap_start    (ap_start),
        .ap_done     (ap_done),
        .ap_idle     (ap_idle),
        .ap_ready    (ap_ready),
        .a           (a),
        .b           (b),
        .zSign       (zSign),
        .ap_return   (ap_return),
        .working_key (working_key)
    );

    // Reference: result = (zs ? -1 : +1) * (|x| - |y|), exact zero is +0.
    function automatic logic [63:0] ref_sub(input logic [63:0] x, input logic [63:0] y, input logic zs);
        real mx, my, d;
        logic xnan, ynan, xinf, yinf;
        logic [63:0] r;
        xnan = (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
        ynan = (y[62:52] == 11'h7FF) && (y[51:0] != 52'd0);
        xinf = (x[62:52] == 11'h7FF) && (x[51:0] == 52'd0);
        yinf = (y[62:52] == 11'h7FF) && (y[51:0] == 52'd0);
        if (xnan || ynan)      r = ynan ? (y | C_QUIET) : (x | C_QUIET);
        else if (xinf && yinf) r = 64'h7FFF_FFFF_FFFF_FFFF;
        else if (xinf)         r = x;
        else if (yinf)         r = {~zs, 11'h7FF, 52'd0};
        else begin
            mx = $bitstoreal({1'b0, x[62:0]});
            my = $bitstoreal({1'b0, y[62:0]});
            d  = mx - my;
            if (d == 0.0) r = 64'd0;
            else begin
                if (zs) d = -d;
                r = $realtobits(d);
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] keyed(input logic [63:0] v, input logic [21:0] k);
        logic [63:0] r;
        r = v;
`ifdef SUB_KEYLOCK_EN
        r[21:0] = v[21:0] ^ (k ^ C_LOCK);
`endif
        return r;
    endfunction

    // Drives one operation; lat is the cycle (1 = first cycle after the accepting
    // edge) in which ap_done was seen, or -1 if it never came.
    task automatic run_op(input logic [63:0] x, input logic [63:0] y, input logic zs,
                          output logic [63:0] res, output int lat,
                          output logic ready_ok, output logic done_next);
        @(negedge ap_clk);
        a = x; b = y; zSign = zs; ap_start = 1'b1;
        @(posedge ap_clk); #1;
        lat = -1;
        ready_ok = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (ap_done) begin
                lat = c;
                ready_ok = (ap_ready === 1'b1);
                break;
            end
            @(posedge ap_clk); #1;
        end
        res = ap_return;
        ap_start = 1'b0;
        @(posedge ap_clk); #1;
        done_next = ap_done;
    endtask

    task automatic test_reset();
        ap_rst = 1'b1; ap_start = 1'b0;
        repeat (2) @(posedge ap_clk);
        #1;
        checks++;
        if (ap_done !== 1'b0 || ap_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_done_ready got done=%b ready=%b expected 0 0", ap_done, ap_ready);
        end
        checks++;
        if (ap_return !== 64'd0) begin
            failures++;
            $display("FAIL reset_return got %h expected 0", ap_return);
        end
        checks++;
        if (ap_idle !== 1'b1) begin
            failures++;
            $display("FAIL reset_idle got %b expected 1", ap_idle);
        end
        ap_start = 1'b1; #1;
        checks++;
        if (ap_idle !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_start got %b expected 0", ap_idle);
        end
        ap_start = 1'b0;
        @(negedge ap_clk);
        ap_rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [63:0] va[8], vb[8], ve[8];
        logic        vz[8];
        logic [63:0] res;
        int          lat;
        logic        rok, dn;
        va = '{64'h4000000000000000, 64'h3FF0000000000000, 64'h3FF0000000000000, 64'h7FF0000000000000,
               64'h7FF0000000000000, 64'h7FF0000000000001, 64'h3FF0000000000000, 64'h0000000000000003};
        vb = '{64'h3FF0000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 64'h7FF0000000000000,
               64'h3FF0000000000000, 64'h3FF0000000000000, 64'hFFF0000000000000, 64'h0000000000000001};
        vz = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        ve = '{64'h3FF0000000000000, 64'h0000000000000000, 64'hBFF0000000000000, 64'h7FFFFFFFFFFFFFFF,
               64'h7FF0000000000000, 64'h7FF8000000000001, 64'h7FF0000000000000, 64'h0000000000000002};
        for (int i = 0; i < 8; i++) begin
            run_op(va[i], vb[i], vz[i], res, lat, rok, dn);
            checks++;
            if (res !== ve[i]) begin
                failures++;
                $display("FAIL directed_result[%0d] got %h expected %h", i, res, ve[i]);
            end
            checks++;
            if (lat != 3 || !rok || dn !== 1'b0) begin
                failures++;
                $display("FAIL directed_timing[%0d] got lat=%0d ready=%b done_after=%b expected 3 1 0",
                         i, lat, rok, dn);
            end
        end
    endtask

    task automatic test_keylock();
        logic [63:0] res, exp;
        int          lat;
        logic        rok, dn;
        working_key = 22'h1;
`ifdef SUB_KEYLOCK_EN
        exp = 64'h3FF0000000000001;
`else
        exp = 64'h3FF0000000000000;
`endif
        run_op(64'h4000000000000000, 64'h3FF0000000000000, 1'b0, res, lat, rok, dn);
        checks++;
        if (res !== exp || lat != 3) begin
            failures++;
            $display("FAIL keylock got %h lat=%0d expected %h lat=3", res, lat, exp);
        end
        working_key = C_LOCK;
    endtask

    task automatic test_random();
        logic [63:0] x, y, res, exp;
        logic        zs, rok, dn;
        int          lat, mode, ebi;
        for (int i = 0; i < 160; i++) begin
            x = {$urandom(), $urandom()};
            y = {$urandom(), $urandom()};
            zs = 1'($urandom_range(0, 1));
            mode = int'($urandom_range(0, 5));
            case (mode)
                1: begin
                    x[62:52] = 11'($urandom_range(1, 2045));
                    ebi = int'(x[62:52]) + int'($urandom_range(0, 4)) - 2;
                    if (ebi < 0) ebi = 0;
                    if (ebi > 2046) ebi = 2046;
                    y[62:52] = 11'(ebi);
                end
                2: begin
                    x[62:52] = 11'($urandom_range(0, 1));
                    y[62:52] = 11'($urandom_range(0, 1));
                end
                3: begin
                    x[62:52] = 11'h7FF;
                    if ($urandom_range(0, 1) == 1) x[51:0] = 52'd0;
                end
                4: y = x ^ 64'($urandom_range(0, 15));
                5: begin
                    y[62:52] = 11'h7FF;
                    if ($urandom_range(0, 1) == 1) y[51:0] = 52'd0;
                end
                default: ;
            endcase
            exp = keyed(ref_sub(x, y, zs), working_key);
            run_op(x, y, zs, res, lat, rok, dn);
            checks++;
            if (res !== exp) begin
                failures++;
                $display("FAIL random_result[%0d] a=%h b=%h zs=%b got %h expected %h", i, x, y, zs, res, exp);
            end
            checks++;
            if (lat != 3) begin
                failures++;
                $display("FAIL random_latency[%0d] got %0d expected 3", i, lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        int c;
        @(negedge ap_clk);
        a = 64'h4000000000000000; b = 64'h3FF0000000000000; zSign = 1'b0; ap_start = 1'b1;
        @(posedge ap_clk); #1;
        c = 1;
        while (!ap_done && c < 8) begin
            @(posedge ap_clk); #1;
            c++;
        end
        checks++;
        if (ap_done !== 1'b1 || c != 3 || ap_return !== 64'h3FF0000000000000) begin
            failures++;
            $display("FAIL b2b_first got done=%b lat=%0d ret=%h expected 1 3 3ff0000000000000",
                     ap_done, c, ap_return);
        end
        a = 64'h4008000000000000; b = 64'h3FF0000000000000; zSign = 1'b1;
        @(posedge ap_clk); #1;
        checks++;
        if (ap_idle !== 1'b0 || ap_done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap got idle=%b done=%b expected 0 0", ap_idle, ap_done);
        end
        c = 1;
        while (!ap_done && c < 10) begin
            @(posedge ap_clk); #1;
            c++;
        end
        checks++;
        if (ap_done !== 1'b1 || c != 4 || ap_return !== 64'hC000000000000000) begin
            failures++;
            $display("FAIL b2b_second got done=%b spacing=%0d ret=%h expected 1 4 c000000000000000",
                     ap_done, c, ap_return);
        end
        ap_start = 1'b0;
        @(posedge ap_clk); #1;
    endtask

    task automatic test_abort();
        int seen;
        @(negedge ap_clk);
        a = 64'h4000000000000000; b = 64'h3FF0000000000000; zSign = 1'b0; ap_start = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b1; ap_start = 1'b0;
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        checks++;
        if (ap_idle !== 1'b1 || ap_return !== 64'd0) begin
            failures++;
            $display("FAIL abort_state got idle=%b ret=%h expected 1 0", ap_idle, ap_return);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge ap_clk); #1;
            if (ap_done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL abort_no_done got %0d done pulses expected 0", seen);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_keylock();
        test_random();
        test_back_to_back();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
